tile_read_seq: RTL and testbench

TILE_READ_SEQ -- requirements
Module: tile_read_seq

---
 rtl/tile_read_pkg.sv | 20 ++
 rtl/trs_pipe.sv | 46 ++++
 rtl/tile_read_seq.sv | 198 +++++++++++++++++++
 tb/tb_tile_read_seq.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_read_pkg.sv
// -----------------------------------------------------------------------------
// tile_read_pkg
// Shared types and width helpers for the tile read sequencer.
//   state_e    : sequencer states (IDLE, READ, DRAIN, DONE)
//   clog2_min1 : ceil(log2(n)), never less than 1, for coordinate port widths
// -----------------------------------------------------------------------------
package tile_read_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/trs_pipe.sv
// -----------------------------------------------------------------------------
// trs_pipe
// Fixed-latency delay line: a beat entering on i_valid/i_data appears on
// o_valid/o_data exactly DEPTH cycles later.
// Ports:
//   clk, reset       : clock, asynchronous active-high reset (clears valids)
//   i_valid, i_data  : beat entering the line
//   o_valid, o_data  : beat leaving the line
// -----------------------------------------------------------------------------
module trs_pipe #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic [DEPTH-1:0] r_valid;
  logic [W-1:0]     r_data [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int i = 1; i < DEPTH; i++) r_valid[i] <= r_valid[i-1];
    end
  end

  // NOTE: the data stages carry no reset; only the valid bits decide whether a
  // stage means anything, and the consumer masks o_data with o_valid.
  always_ff @(posedge clk) begin
    if (i_valid) r_data[0] <= i_data;
    for (int i = 1; i < DEPTH; i++) begin
      if (r_valid[i-1]) r_data[i] <= r_data[i-1];
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/tile_read_seq.sv
// -----------------------------------------------------------------------------
// tile_read_seq
// Sweeps a ROWS x COLS x CHANS tile out of a read memory, one address per
// accepted cycle, in channel-outermost or channel-interleaved order, and
// re-aligns the beat coordinates with the memory data MEM_LAT cycles later.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   data_done                  : level request; high starts a sweep, low
//                                after completion returns to idle
//   chan_major                 : order select latched at sweep start
//                                (1 = channel outermost, 0 = interleaved)
//   out_ready                  : downstream may accept new issues
//   mem_en, mem_addr           : memory read request
//   out_valid, out_row/col/chan, out_last : beat aligned to memory data
//   busy                       : high in READ and DRAIN
//   data_rdy                   : high in DONE
//   stall_cnt                  : READ cycles with out_ready low, saturating;
//                                present only with TILE_READ_STALL_CNT_EN
// -----------------------------------------------------------------------------
module tile_read_seq
  import tile_read_pkg::*;
#(
  parameter int  ROWS    = 8,
  parameter int  COLS    = 8,
  parameter int  CHANS   = 3,
  parameter int  MEM_LAT = 2,
  parameter int  ADDR_W  = 8,
  localparam int ROW_W   = clog2_min1(ROWS),
  localparam int COL_W   = clog2_min1(COLS),
  localparam int CHAN_W  = clog2_min1(CHANS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_done,
  input  logic              chan_major,
  input  logic              out_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              out_valid,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col,
  output logic [CHAN_W-1:0] out_chan,
  output logic              out_last,
  output logic              busy,
  output logic              data_rdy
`ifdef TILE_READ_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int N      = ROWS * COLS * CHANS;
  localparam int BEAT_W = ROW_W + COL_W + CHAN_W + 1;

  if (ADDR_W < $clog2(N)) begin : g_addr_w_check
    $error("tile_read_seq: ADDR_W too narrow for ROWS*COLS*CHANS");
  end

  state_e              r_state, w_next_state;
  logic                r_chan_major;
  logic [ROW_W-1:0]    r_row, w_row_nxt;
  logic [COL_W-1:0]    r_col, w_col_nxt;
  logic [CHAN_W-1:0]   r_chan, w_chan_nxt;
  logic                w_row_last, w_col_last, w_chan_last, w_issue_last;
  logic                w_start;
  logic [BEAT_W-1:0]   w_beat_in, w_beat_out;
  logic                w_pipe_valid, w_pipe_last;

  assign w_row_last   = (r_row  == ROW_W'(ROWS - 1));
  assign w_col_last   = (r_col  == COL_W'(COLS - 1));
  assign w_chan_last  = (r_chan == CHAN_W'(CHANS - 1));
  // The final coordinate is the all-maximum corner in either order.
  assign w_issue_last = w_row_last && w_col_last && w_chan_last;
  assign w_start      = (r_state == ST_IDLE) && data_done;

  // ---------------------------------------------------------------------------
  // State machine
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    mem_en       = 1'b0;
    busy         = 1'b0;
    data_rdy     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (data_done) w_next_state = ST_READ;
      end
      ST_READ: begin
        busy   = 1'b1;
        mem_en = out_ready;
        if (out_ready && w_issue_last) w_next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_pipe_valid && w_pipe_last) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        data_rdy = 1'b1;
        if (!data_done) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Coordinate counters: col -> row -> chan when channel-major, otherwise
  // chan -> col -> row. Each wraps at its exact bound.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_row_nxt  = r_row;
    w_col_nxt  = r_col;
    w_chan_nxt = r_chan;
    if (r_chan_major) begin
      w_col_nxt = w_col_last ? '0 : r_col + COL_W'(1);
      if (w_col_last) begin
        w_row_nxt = w_row_last ? '0 : r_row + ROW_W'(1);
        if (w_row_last) w_chan_nxt = w_chan_last ? '0 : r_chan + CHAN_W'(1);
      end
    end else begin
      w_chan_nxt = w_chan_last ? '0 : r_chan + CHAN_W'(1);
      if (w_chan_last) begin
        w_col_nxt = w_col_last ? '0 : r_col + COL_W'(1);
        if (w_col_last) w_row_nxt = w_row_last ? '0 : r_row + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chan_major <= 1'b0;
      r_row        <= '0;
      r_col        <= '0;
      r_chan       <= '0;
    end else if (w_start) begin
      r_chan_major <= chan_major;
      r_row        <= '0;
      r_col        <= '0;
      r_chan       <= '0;
    end else if (mem_en) begin
      r_row        <= w_row_nxt;
      r_col        <= w_col_nxt;
      r_chan       <= w_chan_nxt;
    end
  end

  // Address is layout-fixed (planar), whatever the traversal order; it follows
  // the counters, so it naturally holds while out_ready is low.
  assign mem_addr = ADDR_W'(r_chan) * ADDR_W'(ROWS * COLS)
                  + ADDR_W'(r_row)  * ADDR_W'(COLS)
                  + ADDR_W'(r_col);

  // ---------------------------------------------------------------------------
  // Beat delay line matching the memory latency
  // ---------------------------------------------------------------------------
  assign w_beat_in = {r_row, r_col, r_chan, w_issue_last};

  trs_pipe #(
    .W     (BEAT_W),
    .DEPTH (MEM_LAT)
  ) u_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (mem_en),
    .i_data  (w_beat_in),
    .o_valid (w_pipe_valid),
    .o_data  (w_beat_out)
  );

  assign w_pipe_last = w_beat_out[0];
  assign out_valid   = w_pipe_valid;
  assign {out_row, out_col, out_chan, out_last} = w_pipe_valid ? w_beat_out : '0;

`ifdef TILE_READ_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_stall_cnt <= '0;
    end else if ((r_state == ST_READ) && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_tile_read_seq.sv
// -----------------------------------------------------------------------------
// tb_tile_read_seq
// Self-checking bench for tile_read_seq: a default-size instance with a
// scoreboard monitor, plus a 3x5x1 instance with MEM_LAT=4.
// -----------------------------------------------------------------------------
module tb_tile_read_seq;

  localparam int ROWS    = 8;
  localparam int COLS    = 8;
  localparam int CHANS   = 3;
  localparam int MEM_LAT = 2;
  localparam int N       = ROWS * COLS * CHANS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       data_done, chan_major, out_ready;
  logic       mem_en, out_valid, out_last, busy, data_rdy;
  logic [7:0] mem_addr;
  logic [2:0] out_row, out_col;
  logic [1:0] out_chan;

  logic       s_data_done, s_chan_major, s_out_ready;
  logic       s_mem_en, s_out_valid, s_out_last, s_busy, s_data_rdy;
  logic [7:0] s_mem_addr;
  logic [1:0] s_out_row;
  logic [2:0] s_out_col;
  logic [0:0] s_out_chan;

`ifdef TILE_READ_STALL_CNT_EN
  logic [15:0] stall_cnt, s_stall_cnt;
`endif

  tile_read_seq u_dut (
    .clk        (clk),
    .reset      (reset),
    .data_done  (data_done),
    .chan_major (chan_major),
    .out_ready  (out_ready),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .out_valid  (out_valid),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_chan   (out_chan),
    .out_last   (out_last),
    .busy       (busy),
    .data_rdy   (data_rdy)
`ifdef TILE_READ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  tile_read_seq #(
    .ROWS    (3),
    .COLS    (5),
    .CHANS   (1),
    .MEM_LAT (4)
  ) u_dut_small (
    .clk        (clk),
    .reset      (reset),
    .data_done  (s_data_done),
    .chan_major (s_chan_major),
    .out_ready  (s_out_ready),
    .mem_en     (s_mem_en),
    .mem_addr   (s_mem_addr),
    .out_valid  (s_out_valid),
    .out_row    (s_out_row),
    .out_col    (s_out_col),
    .out_chan   (s_out_chan),
    .out_last   (s_out_last),
    .busy       (s_busy),
    .data_rdy   (s_data_rdy)
`ifdef TILE_READ_STALL_CNT_EN
    ,
    .stall_cnt  (s_stall_cnt)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int row;
    int col;
    int chan;
    bit last;
    int due;
  } beat_t;

  // Scoreboard for the default instance: each issue is checked against the
  // bench's own traversal model and pushed; each out_valid pops one entry.
  beat_t sb_q[$];
  int    model_k  = 0;
  bit    model_cm = 1'b1;
  beat_t mb, me;
  int    m_ea;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_en) begin
        if (model_cm) begin
          mb.col  = model_k % COLS;
          mb.row  = (model_k / COLS) % ROWS;
          mb.chan = model_k / (ROWS * COLS);
        end else begin
          mb.chan = model_k % CHANS;
          mb.col  = (model_k / CHANS) % COLS;
          mb.row  = model_k / (CHANS * COLS);
        end
        mb.last = (model_k == N - 1);
        mb.due  = cyc + MEM_LAT;
        m_ea    = mb.chan * ROWS * COLS + mb.row * COLS + mb.col;
        n_total++;
        if (model_k >= N)
          $display("FAIL issue_overrun: mem_en high after %0d issues (addr %0d)", N, mem_addr);
        else if (mem_addr !== 8'(m_ea))
          $display("FAIL issue_addr: issue %0d got addr %0d, want %0d", model_k, mem_addr, m_ea);
        else
          n_pass++;
        sb_q.push_back(mb);
        model_k++;
      end
      if (out_valid) begin
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL beat_unexpected: out_valid at cycle %0d with nothing in flight", cyc);
        end else begin
          me = sb_q.pop_front();
          if (out_row !== 3'(me.row) || out_col !== 3'(me.col) || out_chan !== 2'(me.chan)
              || out_last !== me.last || cyc != me.due)
            $display("FAIL beat: got (r%0d c%0d ch%0d last%0b cyc%0d), want (r%0d c%0d ch%0d last%0b cyc%0d)",
                     out_row, out_col, out_chan, out_last, cyc,
                     me.row, me.col, me.chan, me.last, me.due);
          else
            n_pass++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input bit cm);
    chan_major = cm;
    model_cm   = cm;
    model_k    = 0;
    data_done  = 1'b1;
  endtask

  // Waits (bounded) for data_rdy and returns to IDLE.
  task automatic finish_sweep(input string name);
    int got = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (data_rdy) begin
        got = 1;
        break;
      end
    end
    n_total++;
    if (got == 0) $display("FAIL %s_timeout: data_rdy never rose, got 0 want 1", name);
    else          n_pass++;
    @(posedge clk);
    #1;
    data_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    data_done    = 1'b0;
    chan_major   = 1'b0;
    out_ready    = 1'b1;
    s_data_done  = 1'b0;
    s_chan_major = 1'b1;
    s_out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({mem_en, mem_addr, out_valid, out_row, out_col, out_chan, out_last, busy, data_rdy} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {mem_en, mem_addr, out_valid, out_row, out_col, out_chan, out_last, busy, data_rdy});
    else n_pass++;
    n_total++;
    if ({s_mem_en, s_mem_addr, s_out_valid, s_busy, s_data_rdy} !== '0)
      $display("FAIL reset_small: got %h want 0", {s_mem_en, s_mem_addr, s_out_valid, s_busy, s_data_rdy});
    else n_pass++;
`ifdef TILE_READ_STALL_CNT_EN
    n_total++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt);
    else n_pass++;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0 || mem_en !== 1'b0) $display("FAIL idle_after_reset: busy %b mem_en %b want 0 0", busy, mem_en);
    else n_pass++;
  endtask

  task automatic test_chan_major_sweep();
    int s_cyc = cyc;
    int first = -1, last = -1, cnt = 0, lcyc = -1, rdy = -1;
    int lr = -1, lc = -1, lch = -1;
    start_sweep(1'b1);
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (first < 0) first = cyc;
        last = cyc;
        cnt++;
      end
      if (out_valid && out_last) begin
        lcyc = cyc; lr = out_row; lc = out_col; lch = out_chan;
      end
      if (data_rdy) begin
        rdy = cyc;
        break;
      end
    end
    n_total++;
    if (first != s_cyc + 1) $display("FAIL cm1_first_issue: got cycle %0d want %0d", first, s_cyc + 1);
    else n_pass++;
    n_total++;
    if (cnt != N || last - first != N - 1)
      $display("FAIL cm1_issue_run: got %0d issues over %0d cycles want %0d over %0d", cnt, last - first + 1, N, N);
    else n_pass++;
    n_total++;
    if (lcyc != last + MEM_LAT || lr != 7 || lc != 7 || lch != 2)
      $display("FAIL cm1_last_beat: got (%0d,%0d,%0d) at %0d want (7,7,2) at %0d", lr, lc, lch, lcyc, last + MEM_LAT);
    else n_pass++;
    n_total++;
    if (rdy != last + 3) $display("FAIL cm1_data_rdy: got cycle %0d want %0d", rdy, last + 3);
    else n_pass++;
    @(posedge clk);
    #1;
    data_done = 1'b0;
    tick();
    n_total++;
    if (data_rdy !== 1'b0 || busy !== 1'b0) $display("FAIL cm1_idle: data_rdy %b busy %b want 0 0", data_rdy, busy);
    else n_pass++;
  endtask

  task automatic test_interleaved_sweep();
    int a[4];
    int na = 0, lasta = -1;
    start_sweep(1'b0);
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (mem_en) begin
        if (na < 4) begin
          a[na] = int'(mem_addr);
          na++;
        end
        lasta = int'(mem_addr);
      end
      if (data_rdy) break;
    end
    n_total++;
    if (na != 4 || a[0] != 0 || a[1] != 64 || a[2] != 128 || a[3] != 1)
      $display("FAIL cm0_first4: got %0d %0d %0d %0d want 0 64 128 1", a[0], a[1], a[2], a[3]);
    else n_pass++;
    n_total++;
    if (lasta != 191) $display("FAIL cm0_last_addr: got %0d want 191", lasta);
    else n_pass++;
    finish_sweep("cm0");
  endtask

  task automatic test_stall();
    int found = 0, bad = 0, nv = 0;
    out_ready = 1'b1;
    start_sweep(1'b1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_en && mem_addr == 8'd39) begin
        found = 1;
        break;
      end
    end
    n_total++;
    if (found == 0) $display("FAIL stall_reach39: address 39 never issued, got 0 want 1");
    else n_pass++;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (mem_en !== 1'b0 || mem_addr !== 8'd40 || busy !== 1'b1) bad++;
      if (out_valid) nv++;
    end
    n_total++;
    if (bad != 0) $display("FAIL stall_hold: %0d bad cycles (mem_en %b addr %0d) want 0", bad, mem_en, mem_addr);
    else n_pass++;
    n_total++;
    if (nv != 2) $display("FAIL stall_inflight: got %0d beats want 2", nv);
    else n_pass++;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_total++;
    if (mem_en !== 1'b1 || mem_addr !== 8'd40) $display("FAIL stall_resume: mem_en %b addr %0d want 1 40", mem_en, mem_addr);
    else n_pass++;
`ifdef TILE_READ_STALL_CNT_EN
    n_total++;
    if (stall_cnt !== 16'd5) $display("FAIL stall_cnt: got %0d want 5", stall_cnt);
    else n_pass++;
`endif
    finish_sweep("stall");
  endtask

  task automatic test_reset_mid_sweep();
    int found = 0, nv = 0, first = -1;
    start_sweep(1'b1);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mem_en && mem_addr == 8'd100) begin
        found = 1;
        break;
      end
    end
    n_total++;
    if (found == 0) $display("FAIL rst_reach100: address 100 never issued, got 0 want 1");
    else n_pass++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    sb_q.delete();
    #1;
    n_total++;
    if ({mem_en, mem_addr, out_valid, out_row, out_col, out_chan, out_last, busy, data_rdy} !== '0)
      $display("FAIL rst_mid_outputs: got %h want 0",
               {mem_en, mem_addr, out_valid, out_row, out_col, out_chan, out_last, busy, data_rdy});
    else n_pass++;
    data_done = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || mem_en || busy) nv++;
    end
    n_total++;
    if (nv != 0) $display("FAIL rst_quiet: got %0d active cycles want 0", nv);
    else n_pass++;
    @(posedge clk);
    #1;
    start_sweep(1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_en) begin
        first = int'(mem_addr);
        break;
      end
    end
    n_total++;
    if (first != 0) $display("FAIL rst_restart_addr: got %0d want 0", first);
    else n_pass++;
    finish_sweep("rst_restart");
  endtask

  task automatic test_done_hold();
    int got = 0, bad = 0;
    start_sweep(1'b1);
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if (data_rdy) begin
        got = 1;
        break;
      end
    end
    n_total++;
    if (got == 0) $display("FAIL hold_timeout: data_rdy never rose, got 0 want 1");
    else n_pass++;
    repeat (20) begin
      @(negedge clk);
      if (data_rdy !== 1'b1 || mem_en !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL hold_done: %0d cycles left DONE or restarted, want 0", bad);
    else n_pass++;
    @(posedge clk);
    #1;
    data_done = 1'b0;
    @(negedge clk);
    n_total++;
    if (data_rdy !== 1'b1) $display("FAIL hold_drop_same_cycle: data_rdy %b want 1", data_rdy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (data_rdy !== 1'b0 || busy !== 1'b0) $display("FAIL hold_to_idle: data_rdy %b busy %b want 0 0", data_rdy, busy);
    else n_pass++;
  endtask

  task automatic test_small_tile();
    beat_t sq[$];
    beat_t b, e;
    int n_iss = 0, n_beat = 0, last_iss = -1, lcyc = -1, lr = -1, lc = -1, lch = -1;
    s_chan_major = 1'b1;
    s_out_ready  = 1'b1;
    s_data_done  = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_mem_en) begin
        n_total++;
        if (s_mem_addr !== 8'(n_iss)) $display("FAIL small_addr: got %0d want %0d", s_mem_addr, n_iss);
        else n_pass++;
        b.row  = n_iss / 5;
        b.col  = n_iss % 5;
        b.chan = 0;
        b.last = (n_iss == 14);
        b.due  = cyc + 4;
        sq.push_back(b);
        last_iss = cyc;
        n_iss++;
      end
      if (s_out_valid) begin
        n_beat++;
        n_total++;
        if (sq.size() == 0) begin
          $display("FAIL small_beat_unexpected: out_valid at cycle %0d", cyc);
        end else begin
          e = sq.pop_front();
          if (s_out_row !== 2'(e.row) || s_out_col !== 3'(e.col) || s_out_chan !== 1'(e.chan)
              || s_out_last !== e.last || cyc != e.due)
            $display("FAIL small_beat: got (r%0d c%0d ch%0d last%0b cyc%0d) want (r%0d c%0d ch%0d last%0b cyc%0d)",
                     s_out_row, s_out_col, s_out_chan, s_out_last, cyc, e.row, e.col, e.chan, e.last, e.due);
          else n_pass++;
        end
        if (s_out_last) begin
          lcyc = cyc; lr = s_out_row; lc = s_out_col; lch = s_out_chan;
        end
      end
      if (s_data_rdy) break;
    end
    n_total++;
    if (n_iss != 15 || n_beat != 15) $display("FAIL small_count: got %0d issues %0d beats want 15 15", n_iss, n_beat);
    else n_pass++;
    n_total++;
    if (lr != 2 || lc != 4 || lch != 0 || lcyc != last_iss + 4)
      $display("FAIL small_last: got (%0d,%0d,%0d) at %0d want (2,4,0) at %0d", lr, lc, lch, lcyc, last_iss + 4);
    else n_pass++;
    @(posedge clk);
    #1;
    s_data_done = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_chan_major_sweep();
    test_interleaved_sweep();
    test_stall();
    test_reset_mid_sweep();
    test_done_hold();
    test_small_tile();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
